portal_pipe_scheduler: RTL
==========================

Name: portal_pipe_scheduler

Overview:
- Shares one outbound portal word channel between NREQ indication marshallers.
- Each marshaller presents a 144-bit message in the format below; the block grants requesters round-robin, latches the winner, and serializes it as 32-bit words (header first, then payload) with a last-word flag.
- Sits between the generated M2P indication wrappers and the host transport FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXW, 4, maximum message length in 32-bit words, including the header word.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- req_valid  in  NREQ  requester i has a message pending.
- req_data  in  NREQ*144  message i at bits [144*i+143:144*i].
- req_ready  out  NREQ  message i accepted this cycle.
- out_valid  out  1  out_word is valid.
- out_word  out  32  serialized word.
- out_last  out  1  final word of the message.
- out_ready  in  1  downstream accepts the word.
- err_len  out  1  one-cycle pulse: accepted message had an illegal length.
- msg_count  out  32  messages fully emitted; wraps modulo 2^32.

Behaviour:
- Message format:
  - [143:128] method number.
  - [127:112] portal id.
  - [111:16] payload words W0..W2, with W0 = [111:80].
  - [15:0] len = total words including the header.
  - Header word = {method, portal} = [143:112].
- Length clamp:
  - len==0 is treated as 1; len>MAXW is treated as MAXW.
  - Either case pulses err_len in the acceptance cycle. The message is still sent.
- Reset:
  - State IDLE, out_valid=0, out_last=0, out_word=0, req_ready=0, err_len=0.
  - msg_count=0, round-robin pointer rr=0, holding register cleared.
- FSM states: IDLE, EMIT.
  - IDLE: out_valid=0.
  - EMIT: out_valid=1; word index k runs 0..len-1.
  - k=0 → header; k=j → W(j-1). out_last = (k==len-1).
- Grant (combinational, in the same cycle):
  - Grant is legal when the state is IDLE, or when in EMIT with out_last && out_ready (zero-bubble back-to-back).
  - The winner is the first i with req_valid[i], searching rr, rr+1, …, wrapping mod NREQ.
  - req_ready is one-hot on the winner; all zeros if there is no grant.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Acceptance cycle:
  - Latch req_data[winner] and the clamped len.
  - Set rr = (winner+1) mod NREQ.
  - Next cycle: state EMIT, k=0, header on out_word. Latency from acceptance to header is 1 cycle.
- Stall: while out_valid && !out_ready, out_word, out_last and k hold stable.
- Word transfer: on out_valid && out_ready, k increments.
- Last word transferred:
  - msg_count increments.
  - Next state is EMIT(k=0) with the new message if one was granted in that cycle, else IDLE.
- Ordering and source integrity:
  - A requester whose req_valid drops without a grant is simply skipped; there is no state for it.
  - No other requester is granted before the current message's last word transfers.
  - Words of different messages never interleave.
- Pointer stability: rr changes only on a grant. A requester holding req_valid is granted within NREQ messages.
- Reset mid-message: the message is abandoned and not counted; next cycle follows reset values. Requesters re-present their messages.
- Width rules: k is clog2(MAXW) bits; clamp comparisons use all 16 len bits.

Test Plan:
- Single message:
  - Stimulus: req0 presents method=1, portal=5, W0=0xDEADBEEF, len=2, out_ready=1.
  - Response: req_ready[0] in cycle t; out_word=0x00010005 at t+1; 0xDEADBEEF with out_last at t+2; msg_count=1.
- Round robin:
  - Stimulus: all 4 requesters valid continuously, each len=1.
  - Response: grants 0,1,2,3,0; one header per cycle with no bubbles; out_last=1 every word.
- Backpressure:
  - Stimulus: len=4 message; out_ready low for 3 cycles on word 2.
  - Response: out_word and out_last frozen; word order header,W0,W1,W2 preserved; no new req_ready until the last word transfers.
- Length clamp:
  - Stimulus: len=0, then len=9.
  - Response: err_len pulses both times; emits 1 word, then 4 words; msg_count=2.
- Pointer fairness:
  - Stimulus: rr=2 after a grant to req1; req0 and req3 both valid.
  - Response: req3 granted first, then req0.
- Reset mid-emit:
  - Stimulus: RST during word 1 of a len=3 message.
  - Response: next cycle out_valid=0, msg_count=0, rr=0; a re-presented message is emitted in full.

Source files
------------

// File: rtl/portal_pipe_scheduler.sv
// portal_pipe_scheduler: round-robin arbiter that shares one outbound portal
// word channel between NREQ indication marshallers. A granted 144-bit message
// is latched and serialized as 32-bit words (header first, then payload),
// with out_last marking the final word of each message.
module portal_pipe_scheduler #(
    parameter int NREQ = 4,
    parameter int MAXW = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*144-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    output logic [31:0]         out_word,
    output logic                out_last,
    input  logic                out_ready,
    output logic                err_len,
    output logic [31:0]         msg_count
);

    localparam int KW = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          state_r;
    logic [127:0]    hold_r;      // method, portal and payload; len is not kept
    logic [KW-1:0]   k_r;
    logic [KW-1:0]   lastk_r;     // clamped length minus one
    logic [PW-1:0]   rr_r;

    logic            xfer_s;
    logic            last_xfer_s;
    logic            found_s;
    logic            grant_s;
    logic [PW-1:0]   win_s;
    logic [143:0]    sel_s;
    logic [15:0]     len_s;
    logic            bad_len_s;
    logic [KW-1:0]   sel_lastk_s;

    // Word j of a latched message body: j=0 is the header, j>0 is W(j-1).
    function automatic logic [31:0] word_at(input logic [127:0] body, input logic [KW-1:0] idx);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            if (int'(idx) == j) begin
                w = body[127-32*j -: 32];
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    assign xfer_s      = out_valid && out_ready;
    assign last_xfer_s = xfer_s && out_last;

    // Round-robin search for the first valid requester starting at rr.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int j = 0; j < NREQ; j++) begin
            logic [PW:0] cand;
            cand = {1'b0, rr_r} + (PW+1)'(j);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end else begin
                cand = cand;
            end
            if (!found_s && req_valid[cand[PW-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant decision, winner selection, length clamp and error flag.
    always_comb begin
        grant_s     = !RST && found_s && ((state_r == IDLE) || last_xfer_s);
        sel_s       = req_data[144*win_s +: 144];
        len_s       = sel_s[15:0];
        bad_len_s   = (len_s == 16'd0) || (len_s > 16'(MAXW));
        req_ready   = '0;
        if (grant_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        if (len_s == 16'd0) begin
            sel_lastk_s = '0;
        end else if (len_s > 16'(MAXW)) begin
            sel_lastk_s = KW'(MAXW - 1);
        end else begin
            sel_lastk_s = KW'(len_s - 16'd1);
        end
        err_len = grant_s && bad_len_s;
    end

    // Message FSM: latch on grant, serialize words, count completed messages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            out_last  <= 1'b0;
            hold_r    <= 128'd0;
            k_r       <= '0;
            lastk_r   <= '0;
            rr_r      <= '0;
            msg_count <= 32'd0;
        end else begin
            if (last_xfer_s) begin
                msg_count <= msg_count + 32'd1;
            end else begin
                msg_count <= msg_count;
            end
            if (grant_s) begin
                state_r   <= EMIT;
                out_valid <= 1'b1;
                hold_r    <= sel_s[143:16];
                k_r       <= '0;
                lastk_r   <= sel_lastk_s;
                out_word  <= sel_s[143:112];
                out_last  <= (sel_lastk_s == '0);
                rr_r      <= (win_s == PW'(NREQ - 1)) ? '0 : win_s + PW'(1);
            end else if (last_xfer_s) begin
                state_r   <= IDLE;
                out_valid <= 1'b0;
                out_word  <= 32'd0;
                out_last  <= 1'b0;
                k_r       <= '0;
            end else if (xfer_s) begin
                k_r       <= k_r + KW'(1);
                out_word  <= word_at(hold_r, k_r + KW'(1));
                out_last  <= ((k_r + KW'(1)) == lastk_r);
            end else begin
                state_r   <= state_r;
                out_valid <= out_valid;
                out_word  <= out_word;
                out_last  <= out_last;
                k_r       <= k_r;
            end
        end
    end

endmodule
